// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: NOP encoding, entry width helper
// and the base opcode constants used by the front end.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package inst_fetch_buffer_pkg;

    localparam int unsigned INST_W   = 32;
    localparam logic [31:0] INST_NOP = `INST_NOP;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    // Each queue entry carries {pc, inst}.
    function automatic int unsigned ifb_entry_width(input int unsigned xlen);
        return INST_W + xlen;
    endfunction

endpackage

// File: rtl/inst_fetch_buffer_storage.sv
// Data array of the fetch buffer: synchronous write, asynchronous read, no reset on data.
module ifb_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port; contents are only meaningful once counted as occupied.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer between Icache and ID: FIFO with bypass, flush shadow and replay bubbles.
// Optional macro IFB_PERF_CNT_EN adds the saturating bubble counter output ifb_bubble_cnt_o.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_SHADOW = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Icache_ready_i,
    input  logic [31:0]              Icache_inst_i,
    input  logic [XLEN-1:0]          Icache_pc_i,
    input  logic                     fc_stall_id_i,
    input  logic                     fc_flush_id_i,
    input  logic                     id_replay_i,
    output logic [31:0]              ifb_inst_o,
    output logic [XLEN-1:0]          ifb_pc_o,
    output logic                     ifb_valid_o,
    output logic                     ifb_full_o,
    output logic [$clog2(DEPTH):0]   ifb_count_o,
    output logic                     ifb_overflow_o
`ifdef IFB_PERF_CNT_EN
    ,output logic [31:0]             ifb_bubble_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = ifb_entry_width(XLEN);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [2:0]    SHADOW_C = 3'(FLUSH_SHADOW);

    logic [PW-1:0] rd_ptr_r, wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [2:0]    shadow_r;
    logic          overflow_r;

    logic          accept_s, empty_s, full_s, bubble_s, cand_s;
    logic          valid_s, pop_s, pop_store_s, push_s, drop_s;
    logic [EW-1:0] rd_data_s;
    logic [31:0]   inst_s;
    logic [XLEN-1:0] pc_s;

    ifb_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata ({Icache_pc_i, Icache_inst_i}),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Head selection (storage or bypass), bubble insertion and push/pop decisions.
    always_comb begin
        accept_s    = Icache_ready_i && (shadow_r == 3'd0) && !fc_flush_id_i;
        empty_s     = (count_r == {CW{1'b0}});
        full_s      = (count_r == DEPTH_C);
        bubble_s    = id_replay_i && !fc_stall_id_i;
        cand_s      = 1'b0;
        inst_s      = INST_NOP;
        pc_s        = {XLEN{1'b0}};
        if (fc_flush_id_i) begin
            cand_s = 1'b0;
        end else if (!empty_s) begin
            cand_s = 1'b1;
            inst_s = rd_data_s[31:0];
            pc_s   = rd_data_s[EW-1:32];
        end else if (accept_s) begin
            cand_s = 1'b1;
            inst_s = Icache_inst_i;
            pc_s   = Icache_pc_i;
        end else begin
            cand_s = 1'b0;
        end
        valid_s     = cand_s && !bubble_s;
        pop_s       = valid_s && !fc_stall_id_i && !id_replay_i;
        pop_store_s = pop_s && !empty_s;
        // A bypassed word consumed this cycle never enters storage.
        push_s      = accept_s && !(pop_s && empty_s) && (!full_s || pop_s);
        drop_s      = accept_s && full_s && !pop_s;
    end

    // Queue pointers, occupancy, flush shadow and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            shadow_r   <= 3'd0;
            overflow_r <= 1'b0;
        end else if (fc_flush_id_i) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            shadow_r   <= SHADOW_C;
            overflow_r <= 1'b0;
        end else begin
            if (pop_store_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_store_s};
            if (shadow_r != 3'd0) begin
                shadow_r <= shadow_r - 3'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign ifb_valid_o    = valid_s;
    assign ifb_inst_o     = valid_s ? inst_s : INST_NOP;
    assign ifb_pc_o       = pc_s;
    assign ifb_full_o     = (count_r == DEPTH_C);
    assign ifb_count_o    = count_r;
    assign ifb_overflow_o = overflow_r;

`ifdef IFB_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;

    // Idle/bubble cycles seen by an unstalled ID; survives flush, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= 32'd0;
        end else if (!valid_s && !fc_stall_id_i && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end
    end

    assign ifb_bubble_cnt_o = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int FS    = 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Icache_ready_i = 1'b0;
    logic [31:0] Icache_inst_i = 32'd0;
    logic [31:0] Icache_pc_i = 32'd0;
    logic        fc_stall_id_i = 1'b0;
    logic        fc_flush_id_i = 1'b0;
    logic        id_replay_i = 1'b0;
    logic [31:0] ifb_inst_o;
    logic [31:0] ifb_pc_o;
    logic        ifb_valid_o;
    logic        ifb_full_o;
    logic [2:0]  ifb_count_o;
    logic        ifb_overflow_o;
`ifdef IFB_PERF_CNT_EN
    logic [31:0] ifb_bubble_cnt_o;
`endif

    inst_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .FLUSH_SHADOW(FS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Icache_ready_i (Icache_ready_i),
        .Icache_inst_i  (Icache_inst_i),
        .Icache_pc_i    (Icache_pc_i),
        .fc_stall_id_i  (fc_stall_id_i),
        .fc_flush_id_i  (fc_flush_id_i),
        .id_replay_i    (id_replay_i),
        .ifb_inst_o     (ifb_inst_o),
        .ifb_pc_o       (ifb_pc_o),
        .ifb_valid_o    (ifb_valid_o),
        .ifb_full_o     (ifb_full_o),
        .ifb_count_o    (ifb_count_o),
        .ifb_overflow_o (ifb_overflow_o)
`ifdef IFB_PERF_CNT_EN
        ,.ifb_bubble_cnt_o (ifb_bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: queue of {pc, inst}
    logic [63:0] q[$];
    int          shadow = 0;
    bit          ovf = 0;
    longint      perf = 0;
    logic [31:0] pc_gen = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        Icache_ready_i = 1'b0;
        fc_stall_id_i = 1'b0;
        fc_flush_id_i = 1'b0;
        id_replay_i = 1'b0;
        #1;
        check_eq("rst_valid", 64'(ifb_valid_o), 64'd0);
        check_eq("rst_inst", 64'(ifb_inst_o), 64'(NOP));
        check_eq("rst_pc", 64'(ifb_pc_o), 64'd0);
        check_eq("rst_count", 64'(ifb_count_o), 64'd0);
        check_eq("rst_full", 64'(ifb_full_o), 64'd0);
        check_eq("rst_ovf", 64'(ifb_overflow_o), 64'd0);
        q.delete();
        shadow = 0;
        ovf = 0;
        perf = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rdy, input logic [31:0] inst, input logic [31:0] pc,
                        input logic st, input logic fl, input logic rp);
        bit          accept, cand, valid, pop, bubble;
        logic [63:0] head;
        int          size0;
        @(negedge clk);
        Icache_ready_i = rdy;
        Icache_inst_i  = inst;
        Icache_pc_i    = pc;
        fc_stall_id_i  = st;
        fc_flush_id_i  = fl;
        id_replay_i    = rp;
        #1;
        size0  = q.size();
        accept = rdy && (shadow == 0) && !fl;
        cand   = 1'b0;
        head   = 64'd0;
        if (!fl && size0 > 0) begin
            cand = 1'b1;
            head = q[0];
        end else if (!fl && accept) begin
            cand = 1'b1;
            head = {pc, inst};
        end
        bubble = rp && !st;
        valid  = cand && !bubble;
        pop    = valid && !st && !rp;

        check_eq("valid", 64'(ifb_valid_o), 64'(valid));
        check_eq("inst", 64'(ifb_inst_o), valid ? 64'(head[31:0]) : 64'(NOP));
        if (!fl) check_eq("pc", 64'(ifb_pc_o), 64'(head[63:32]));
        check_eq("count", 64'(ifb_count_o), 64'(size0));
        check_eq("full", 64'(ifb_full_o), 64'(size0 == DEPTH));
        check_eq("ovf", 64'(ifb_overflow_o), 64'(ovf));
`ifdef IFB_PERF_CNT_EN
        check_eq("perf", 64'(ifb_bubble_cnt_o), 64'(perf));
`endif
        if (!valid && !st) perf++;
        if (fl) begin
            q.delete();
            shadow = FS;
            ovf = 0;
        end else begin
            if (pop && size0 > 0) void'(q.pop_front());
            if (accept && !(pop && size0 == 0)) begin
                if (size0 < DEPTH || pop) q.push_back({pc, inst});
                else ovf = 1;
            end
            if (shadow > 0) shadow--;
        end
    endtask

    task automatic fetch(input logic st, input logic rp);
        step(1'b1, $urandom, pc_gen, st, 1'b0, rp);
        pc_gen = pc_gen + 32'd4;
    endtask

    task automatic idle(input logic st);
        step(1'b0, 32'd0, 32'd0, st, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();

        // Streaming bypass
        for (int i = 0; i < 8; i++) fetch(1'b0, 1'b0);

        // Stall fill with a rogue fifth and sixth word, then drain in order
        for (int i = 0; i < 6; i++) fetch(1'b1, 1'b0);
        check_eq("fill_ovf", 64'(ifb_overflow_o), 64'd1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Flush with count=3, words in flush cycle and shadow dropped
        for (int i = 0; i < 3; i++) fetch(1'b1, 1'b0);
        step(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0060_0113, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0070_0193, 32'h108, 1'b0, 1'b0, 1'b0);
        check_eq("post_flush_cnt", 64'(ifb_count_o), 64'd0);

        // Replay bubble on a stored head
        step(1'b1, 32'h0000_A103, 32'h200, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // Full with simultaneous pop across pointer wrap
        for (int i = 0; i < 4; i++) fetch(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) fetch(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Reset mid-stall with count=2, no stale word afterwards
        fetch(1'b1, 1'b0);
        fetch(1'b1, 1'b0);
        do_reset();
        idle(1'b0);
        fetch(1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic rdy, st, fl, rp;
            rdy = ($urandom % 4) != 0;
            st  = ($urandom % 3) == 0;
            rp  = ($urandom % 8) == 0;
            fl  = ($urandom % 32) == 0;
            step(rdy, $urandom, pc_gen, st, fl, rp);
            if (rdy) pc_gen = pc_gen + 32'd4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Parametrised instruction queue between the Icache and the ID stage. It replaces the fixed two-entry stall buffer with a DEPTH-entry FIFO that carries PC and instruction together. It also provides first-word-fall-through bypass, a flush shadow that drops wrong-path words, load-use replay bubbles and an overflow check. ID consumes ifb_inst_o/ifb_pc_o directly.

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2
XLEN, 32, PC width
FLUSH_SHADOW, 1, cycles after a flush during which returning Icache words are discarded (0..7)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
Icache_ready_i  in  1  Icache returns a valid word this cycle
Icache_inst_i  in  32  returned instruction
Icache_pc_i  in  XLEN  PC of returned instruction
fc_stall_id_i  in  1  ID stalled; hold head
fc_flush_id_i  in  1  flush queue
id_replay_i  in  1  load-use hazard; insert bubble, hold head
ifb_inst_o  out  32  instruction to ID (NOP 32'h0000_0013 when not valid or bubble)
ifb_pc_o  out  XLEN  PC to ID
ifb_valid_o  out  1  ifb_inst_o is a real instruction
ifb_full_o  out  1  count==DEPTH; fetch must not issue
ifb_count_o  out  $clog2(DEPTH)+1  occupancy
ifb_overflow_o  out  1  sticky: word arrived while full with no pop

Behaviour:
- Reset (async, rst_n=0): count=0, rd/wr ptrs=0, shadow=0, overflow=0. Outputs are inst=NOP, pc=0, valid=0, full=0.
- Clock and reset: single clock clk; reset is asynchronous, active-low, on rst_n.
- accept = Icache_ready_i && shadow==0 && !fc_flush_id_i.
- Output selection:
  - count>0: output the head entry.
  - count==0 && accept: output the incoming word combinationally (bypass).
  - otherwise: valid=0, inst=NOP, pc=0.
- Bubble: id_replay_i && !fc_stall_id_i forces inst=NOP and valid=0 for that cycle. The head is not popped; pc still shows the head.
- pop = ifb_valid_o && !fc_stall_id_i && !id_replay_i.
- Bypass case: if count==0 and the incoming word is popped the same cycle, it is not stored. If it is not popped (stall or replay), it is written, count becomes 1 and the same word is presented next cycle.
- Push:
  - Push when accept and the word is not consumed by bypass, and (count<DEPTH or pop).
  - Full with simultaneous pop: the push is allowed and count stays at DEPTH.
  - Full without pop: the word is dropped and overflow is set to 1.
- Count: count_next = count + push − pop_from_storage. Pointers wrap modulo DEPTH.
- Stall: head and outputs are held stable. Pushes continue until full.
- Stall and replay together: stall wins; the real head is shown with valid=1.
- Flush (highest priority):
  - Next cycle: count=0, ptrs=0, overflow=0, shadow=FLUSH_SHADOW.
  - Flush-cycle outputs: inst=NOP, valid=0.
  - The Icache word arriving in the flush cycle is discarded.
- Shadow counter: decrements by 1 per cycle while nonzero. While nonzero, Icache words are discarded. A flush during the shadow reloads it.
- ifb_full_o and ifb_count_o are registered-state derived, with no combinational path from Icache_ready_i.
- Reset mid-operation: immediate return to reset state. In-flight words are lost.

Optional Feature:
IFB_PERF_CNT_EN:
- Defined: adds output ifb_bubble_cnt_o[31:0], a saturating counter.
  - Increments each cycle ifb_valid_o==0 && !fc_stall_id_i (replay bubbles included).
  - Cleared only by reset, not by flush.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared define/package: `INST_NOP (32'h0000_0013) and the entry width (32+XLEN). The existing instruction-opcode defines stay there.
- Sub-module ifb_storage:
  - DEPTH×(32+XLEN) register array.
  - Synchronous write port, asynchronous read port; no reset on the data array.
- The top holds pointers, count, shadow, overflow, bypass mux and optional perf counter.

Test Plan:
- Streaming: one word per cycle (PC 0x0,0x4,…), no stall → each word out same cycle via bypass; count stays 0; valid=1 every cycle.
- Stall fill: stall for 6 cycles while 6 words arrive, DEPTH=4 → 4 stored, full=1 at count 4. Fetch obeys full; a rogue 5th word sets overflow=1. After release, pops appear in order, one per cycle.
- Flush: count=3, assert flush; Icache returns 0x00500093 that cycle and 0x00600113 next → both dropped (FLUSH_SHADOW=1). Outputs are NOP/valid=0, count=0. Third word is bypassed out.
- Replay: head 0x0000A103, id_replay_i for 1 cycle → inst=NOP, valid=0, count unchanged. Next cycle 0x0000A103 is popped.
- Full with pop: count=4, a word arrives with pop → count stays 4, no overflow, FIFO order preserved across pointer wrap.
- Reset mid-stall with count=2 → all outputs at reset values immediately; no stale word after rst_n rises.
